// File: rtl/mul_mid_pkg.sv
// Shared definitions for the middle-bits multiplier scheduler: FSM states and width defaults.
package mul_mid_pkg;

    localparam int unsigned MulSizeDef = 56;
    localparam int unsigned RadixDef   = 54;
    localparam int unsigned MulLatDef  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    // Index width that stays legal for a single requester.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant from a request vector; the pointer moves past the
// winner only when advance is strobed and something was granted.
module rr_arb import mul_mid_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdW = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] win;
    logic           found;

    // Second pass overrides the first, so the lowest index at or above the pointer wins,
    // falling back to the lowest index below it.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i] && (IdW'(i) < ptr_q)) begin
                win   = IdW'(i);
                found = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i] && (IdW'(i) >= ptr_q)) begin
                win   = IdW'(i);
                found = 1'b1;
            end
        end
        gnt_o = '0;
        if (found) begin
            gnt_o[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && found) begin
            ptr_d = (win == IdW'(NUM_REQ - 1)) ? '0 : win + IdW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_mid_sched.sv
// Shares one external multiplier among NUM_REQ requesters and returns product bits
// [2*RADIX-1:RADIX]. Define MUL_MID_SCHED_PERF_CNT_EN to count completed operations.
module mul_mid_sched import mul_mid_pkg::*; #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MUL_SIZE = MulSizeDef,
    parameter int unsigned RADIX    = RadixDef,
    parameter int unsigned MUL_LAT  = MulLatDef,
    localparam int unsigned IdW     = clog2_min1(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*MUL_SIZE-1:0] req_a,
    input  logic [NUM_REQ*MUL_SIZE-1:0] req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IdW-1:0]              rsp_id,
    output logic [RADIX-1:0]            rsp_data,
    output logic                        mul_en,
    output logic [MUL_SIZE-1:0]         mul_a,
    output logic [MUL_SIZE-1:0]         mul_b,
    input  logic [RADIX-1:0]            mul_res,
    output logic                        busy,
    output logic [31:0]                 op_count
);

    localparam int unsigned CntW = clog2_min1(MUL_LAT + 1);

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic                mul_en_q;
    logic [MUL_SIZE-1:0] mul_a_q, mul_b_q;
    logic [IdW-1:0]      rsp_id_q;
    logic [RADIX-1:0]    rsp_data_q;
    logic                rsp_valid_q;
    logic                busy_q;

    logic                grant_en;
    logic [NUM_REQ-1:0]  req_masked;
    logic [NUM_REQ-1:0]  gnt;
    logic [IdW-1:0]      gnt_id;
    logic [MUL_SIZE-1:0] a_sel, b_sel;

    // Grants are only offered from IDLE and never while reset is asserted.
    assign grant_en   = rst_n && (state_q == StIdle);
    assign req_masked = req_valid & {NUM_REQ{grant_en}};

    rr_arb #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req_i(req_masked),
        .adv_i(grant_en),
        .gnt_o(gnt)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IdW'(i);
            end
        end
    end

    assign a_sel = req_a[gnt_id*MUL_SIZE +: MUL_SIZE];
    assign b_sel = req_b[gnt_id*MUL_SIZE +: MUL_SIZE];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        mul_a_q  <= a_sel;
                        mul_b_q  <= b_sel;
                        rsp_id_q <= gnt_id;
                        mul_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    mul_en_q <= 1'b0;
                    cnt_q    <= CntW'(1);
                    state_q  <= StWait;
                end
                StWait: begin
                    if (cnt_q == CntW'(MUL_LAT)) begin
                        rsp_data_q  <= mul_res;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign mul_en    = mul_en_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = busy_q;

`ifdef MUL_MID_SCHED_PERF_CNT_EN
    logic [31:0] op_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else if ((state_q == StResp) && rsp_ready) begin
            op_cnt_q <= op_cnt_q + 32'd1;
        end
    end

    assign op_count = op_cnt_q;
`else
    assign op_count = 32'd0;
`endif

endmodule
